// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM: one shared edge/center-aligned counter, double-buffered period/mode/duty.
// Outputs registered with zero latency relative to count; enable low stalls everything, writes still land.
module pwm_multi_ch #(
    parameter int WIDTH    = 10,
    parameter int CHANNELS = 4,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [WIDTH-1:0]    period,
    input  logic                center_mode,
    input  logic                duty_wr,
    input  logic [CH_W-1:0]     duty_ch,
    input  logic [WIDTH-1:0]    duty_val,
    output logic [WIDTH-1:0]    count,
    output logic                dir_down,
    output logic                period_end,
    output logic [CHANNELS-1:0] pwm_out
);

    logic [WIDTH-1:0]    count_q, count_d;
    logic                dir_q, dir_d;
    logic [WIDTH-1:0]    p_act_q, p_act_d;
    logic                mode_q, mode_d;
    logic                pe_q, pe_d;
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic [WIDTH-1:0]    pend_q [CHANNELS];
    logic [WIDTH-1:0]    pend_d [CHANNELS];
    logic [WIDTH-1:0]    act_q  [CHANNELS];
    logic [WIDTH-1:0]    act_d  [CHANNELS];
    logic                reload;

    always_comb begin
        reload  = 1'b0;
        pend_d  = pend_q;
        act_d   = act_q;
        p_act_d = p_act_q;
        mode_d  = mode_q;
        count_d = count_q;
        dir_d   = dir_q;
        pe_d    = 1'b0;
        pwm_d   = '0;

        if (enable) begin
            reload = mode_q ? (count_q == '0) : (count_q == p_act_q);
        end

        if (duty_wr && (int'(duty_ch) < CHANNELS)) begin
            pend_d[duty_ch] = duty_val;
        end

        if (reload) begin
            // Active set takes the pending values as they stood before this cycle's write.
            act_d   = pend_q;
            p_act_d = period;
            mode_d  = center_mode;
            pe_d    = 1'b1;
            dir_d   = 1'b0;
            count_d = ((count_q == '0) && (period != '0)) ? WIDTH'(1) : '0;
        end else if (enable) begin
            if (!mode_q) begin
                count_d = count_q + 1'b1;
                dir_d   = 1'b0;
            end else if (!dir_q && (count_q != p_act_q)) begin
                count_d = count_q + 1'b1;
            end else begin
                count_d = count_q - 1'b1;
                dir_d   = (count_d != '0);
            end
        end

        // Compare against next-state values so the registered output lines up with count.
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = (count_d < act_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            dir_q   <= 1'b0;
            p_act_q <= '0;
            mode_q  <= 1'b0;
            pe_q    <= 1'b0;
            pwm_q   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                pend_q[i] <= '0;
                act_q[i]  <= '0;
            end
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            p_act_q <= p_act_d;
            mode_q  <= mode_d;
            pe_q    <= pe_d;
            pwm_q   <= pwm_d;
            pend_q  <= pend_d;
            act_q   <= act_d;
        end
    end

    assign count      = count_q;
    assign dir_down   = dir_q;
    assign period_end = pe_q;
    assign pwm_out    = pwm_q;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed stimulus for pwm_multi_ch; expected per-cycle state is queued by the driver
// and checked by an independent monitor on the falling edge.
module tb_pwm_multi_ch;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [9:0] period;
    logic       center_mode;
    logic       duty_wr;
    logic [1:0] duty_ch;
    logic [9:0] duty_val;
    logic [9:0] count;
    logic       dir_down;
    logic       period_end;
    logic [3:0] pwm_out;

    pwm_multi_ch #(.WIDTH(10), .CHANNELS(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .period      (period),
        .center_mode (center_mode),
        .duty_wr     (duty_wr),
        .duty_ch     (duty_ch),
        .duty_val    (duty_val),
        .count       (count),
        .dir_down    (dir_down),
        .period_end  (period_end),
        .pwm_out     (pwm_out)
    );

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  ph;
        logic [9:0]  cnt;
        logic        dir;
        logic        pe;
        logic [3:0]  pwm;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   ph  = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    int ctab [8] = '{1, 2, 3, 4, 3, 2, 1, 0};
    int dtab [8] = '{0, 0, 0, 0, 1, 1, 1, 0};
    int wtab [4] = '{3, 0, 10, 9};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_st(input int c, input logic d, input logic p, input logic [3:0] w);
        exp_t e;
        e.cyc = cyc;
        e.ph  = 8'(ph);
        e.cnt = 10'(c);
        e.dir = d;
        e.pe  = p;
        e.pwm = w;
        sb.push_back(e);
    endtask

    function automatic logic [3:0] pw(input int c, input int a, input int b, input int e, input int f);
        return {c < f, c < e, c < b, c < a};
    endfunction

    task automatic cmp(input string nm, input int ph_i, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_err++;
            $display("FAIL %s phase=%0d cyc=%0d got=%0d want=%0d", nm, ph_i, cyc, act, want);
        end
    endtask

    // Monitor: pops the entry queued for this cycle and compares every output field.
    always @(negedge clk) begin
        while (sb.size() > 0 && int'(sb[0].cyc) < cyc) begin
            exp_t s;
            s = sb.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL stale_entry phase=%0d cyc=%0d got=%0d want=%0d", s.ph, cyc, cyc, s.cyc);
        end
        if (sb.size() > 0 && int'(sb[0].cyc) == cyc) begin
            exp_t e;
            e = sb.pop_front();
            cmp("count",      e.ph, count,      e.cnt);
            cmp("dir_down",   e.ph, dir_down,   e.dir);
            cmp("period_end", e.ph, period_end, e.pe);
            cmp("pwm_out",    e.ph, pwm_out,    e.pwm);
        end
    end

    initial begin
        int c;
        reset = 1'b1; enable = 1'b0; period = '0; center_mode = 1'b0;
        duty_wr = 1'b0; duty_ch = '0; duty_val = '0;

        // Reset state
        ph = 0;
        step(); expect_st(0, 0, 0, 4'b0000);

        // Edge mode P=9, duties 3/0/10/9
        ph = 1;
        reset = 1'b0; period = 10'd9;
        for (int i = 0; i < 4; i++) begin
            duty_wr = 1'b1; duty_ch = 2'(i); duty_val = 10'(wtab[i]);
            step(); expect_st(0, 0, 0, 4'b0000);
        end
        duty_wr = 1'b0; enable = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            step(); c = k % 10;
            expect_st(c, 0, (k == 1) || (c == 0), pw(c, 3, 0, 10, 9));
        end

        // Mid-period write of ch0=7 and period=4 waits for the reload at count 9
        ph = 3;
        duty_wr = 1'b1; duty_ch = 2'd0; duty_val = 10'd7; period = 10'd4;
        step(); expect_st(6, 0, 0, pw(6, 3, 0, 10, 9));
        duty_wr = 1'b0;
        for (int k = 7; k <= 9; k++) begin
            step(); expect_st(k, 0, 0, pw(k, 3, 0, 10, 9));
        end
        for (int m = 0; m < 10; m++) begin
            step(); c = m % 5;
            expect_st(c, 0, c == 0, pw(c, 7, 0, 10, 9));
        end

        // Write ch1 on the reload cycle itself
        ph = 4;
        duty_wr = 1'b1; duty_ch = 2'd1; duty_val = 10'd2;
        step(); expect_st(0, 0, 1, pw(0, 7, 0, 10, 9));
        duty_wr = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            step(); expect_st(n, 0, 0, pw(n, 7, 0, 10, 9));
        end
        for (int n = 5; n <= 9; n++) begin
            step(); c = n - 5;
            expect_st(c, 0, c == 0, pw(c, 7, 2, 10, 9));
        end

        // Stall at count 6 with a pending write during the stall
        ph = 5;
        period = 10'd9;
        for (int k = 0; k <= 6; k++) begin
            step(); expect_st(k, 0, k == 0, pw(k, 7, 2, 10, 9));
        end
        enable = 1'b0; duty_wr = 1'b1; duty_ch = 2'd0; duty_val = 10'd1;
        for (int j = 0; j < 6; j++) begin
            step(); expect_st(6, 0, 0, pw(6, 7, 2, 10, 9));
            duty_wr = 1'b0;
        end
        enable = 1'b1;
        for (int k = 7; k <= 9; k++) begin
            step(); expect_st(k, 0, 0, pw(k, 7, 2, 10, 9));
        end
        for (int k = 0; k <= 9; k++) begin
            duty_wr = (k == 1); duty_ch = 2'd0; duty_val = 10'd2;
            step(); expect_st(k, 0, k == 0, pw(k, 1, 2, 10, 9));
        end
        duty_wr = 1'b0;

        // Edge -> center switch at count 9, then center P=4
        ph = 2;
        center_mode = 1'b1; period = 10'd4;
        step(); expect_st(0, 0, 1, pw(0, 2, 2, 10, 9));
        for (int s = 1; s <= 16; s++) begin
            int t;
            t = (s - 1) % 8;
            step();
            expect_st(ctab[t], dtab[t][0], t == 0, pw(ctab[t], 2, 2, 10, 9));
        end

        // Center P=8, reset while descending at count 7
        ph = 6;
        period = 10'd8;
        for (int k = 1; k <= 8; k++) begin
            step(); expect_st(k, 0, k == 1, pw(k, 2, 2, 10, 9));
        end
        step(); expect_st(7, 1, 0, pw(7, 2, 2, 10, 9));
        reset = 1'b1;
        step(); expect_st(0, 0, 0, 4'b0000);
        reset = 1'b0; enable = 1'b0; center_mode = 1'b0; period = 10'd3;
        duty_wr = 1'b1; duty_ch = 2'd0; duty_val = 10'd2;
        step(); expect_st(0, 0, 0, 4'b0000);
        duty_wr = 1'b0; enable = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(); c = k % 4;
            expect_st(c, 0, (k == 1) || (c == 0), pw(c, 2, 0, 0, 0));
        end

        step(); step();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
